// File: rtl/vpp_meter_if.sv
// vpp_meter_if: sample/command inputs and result outputs of the peak-to-peak meter.
//   master: drives Datain, Datain_valid, Times, Hold, Clear; observes results.
//   slave : the meter; consumes samples, drives Max, Min, Vpp, Max_idx, Sum, Vpp_found.
interface vpp_meter_if #(
  parameter int DATA_W = 12,
  parameter int CNT_W  = 32
);
  logic [DATA_W-1:0]       Datain;
  logic                    Datain_valid;
  logic [CNT_W-1:0]        Times;
  logic                    Hold;
  logic                    Clear;
  logic [DATA_W-1:0]       Max;
  logic [DATA_W-1:0]       Min;
  logic [DATA_W:0]         Vpp;
  logic [CNT_W-1:0]        Max_idx;
  logic [DATA_W+CNT_W-1:0] Sum;
  logic                    Vpp_found;

  modport master (
    output Datain, Datain_valid, Times, Hold, Clear,
    input  Max, Min, Vpp, Max_idx, Sum, Vpp_found
  );
  modport slave (
    input  Datain, Datain_valid, Times, Hold, Clear,
    output Max, Min, Vpp, Max_idx, Sum, Vpp_found
  );
endinterface

// File: rtl/vpp_meter.sv
// vpp_meter: windowed peak-to-peak meter on the ADC sample clock.
//   clk_sample : sample clock (only clock)
//   rst        : synchronous active-high reset
//   bus        : vpp_meter_if.slave -- samples, window length, hold/clear
//                commands in; max/min/vpp/max index/sum and Vpp_found out.
// Over each window of max(Times,1) accepted samples it tracks max, min, sum
// and the window index of the max, then publishes them with a one-cycle
// Vpp_found pulse. In hold mode max/min carry across windows until Clear.
module vpp_meter #(
  parameter int DATA_W = 12,
  parameter int CNT_W  = 32,
  parameter int SIGNED = 0
) (
  input  logic        clk_sample,
  input  logic        rst,
  vpp_meter_if.slave  bus
);
  localparam int SW = DATA_W + CNT_W;

  logic [CNT_W-1:0]  r_cnt, r_told, r_idx;
  logic [DATA_W-1:0] r_max, r_min;
  logic [SW-1:0]     r_sum;
  logic              r_empty, r_hold;

  logic [DATA_W-1:0] r_omax, r_omin;
  logic [DATA_W:0]   r_ovpp;
  logic [CNT_W-1:0]  r_oidx;
  logic [SW-1:0]     r_osum;
  logic              r_found;

  logic [CNT_W-1:0]  w_tlen, w_idx;
  logic [DATA_W-1:0] w_max, w_min;
  logic [SW-1:0]     w_ext, w_sum;
  logic [DATA_W:0]   w_vpp;
  logic              w_abort, w_acc, w_last, w_sbit;

  function automatic logic gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    else             return a > b;
  endfunction

  // Times==0 behaves as a one-sample window.
  assign w_tlen  = (bus.Times == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : bus.Times;
  // A Times change is seen for exactly one cycle since r_told follows every cycle.
  assign w_abort = bus.Clear | (bus.Times != r_told);
  assign w_acc   = bus.Datain_valid & ~w_abort;
  assign w_last  = w_acc & (r_cnt == (w_tlen - 1'b1));
  assign w_sbit  = (SIGNED != 0) & bus.Datain[DATA_W-1];
  assign w_ext   = {{CNT_W{w_sbit}}, bus.Datain};
  assign w_sum   = r_sum + w_ext;

  // Accumulator values including the incoming sample.
  always_comb begin
    w_max = r_max;
    w_min = r_min;
    w_idx = r_idx;
    if (r_empty) begin
      w_max = bus.Datain;
      w_min = bus.Datain;
      w_idx = r_cnt;
    end else begin
      if (gt(bus.Datain, r_max)) begin
        w_max = bus.Datain;
        w_idx = r_cnt;
      end
      if (gt(r_min, bus.Datain)) w_min = bus.Datain;
    end
  end

  // Extend one bit per signedness so the difference is always non-negative.
  assign w_vpp = {((SIGNED != 0) & w_max[DATA_W-1]), w_max}
               - {((SIGNED != 0) & w_min[DATA_W-1]), w_min};

  always_ff @(posedge clk_sample) begin
    if (rst) begin
      r_cnt   <= '0;
      r_told  <= bus.Times;
      r_idx   <= '0;
      r_max   <= '0;
      r_min   <= '0;
      r_sum   <= '0;
      r_empty <= 1'b1;
      r_hold  <= 1'b0;
      r_omax  <= '0;
      r_omin  <= '0;
      r_ovpp  <= '0;
      r_oidx  <= '0;
      r_osum  <= '0;
      r_found <= 1'b0;
    end else begin
      r_told  <= bus.Times;
      r_found <= 1'b0;
      if (w_abort) begin
        r_cnt   <= '0;
        r_sum   <= '0;
        r_idx   <= '0;
        r_empty <= 1'b1;
      end else if (w_acc) begin
        r_max   <= w_max;
        r_min   <= w_min;
        r_idx   <= w_idx;
        r_empty <= 1'b0;
        if (w_last) begin
          r_omax  <= w_max;
          r_omin  <= w_min;
          r_ovpp  <= w_vpp;
          r_oidx  <= w_idx;
          r_osum  <= w_sum;
          r_found <= 1'b1;
          r_cnt   <= '0;
          r_sum   <= '0;
          r_hold  <= bus.Hold;
          // Without hold the next window re-seeds max/min from its first sample.
          if (!bus.Hold) r_empty <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
          r_sum <= w_sum;
        end
      end
    end
  end

  assign bus.Max       = r_omax;
  assign bus.Min       = r_omin;
  assign bus.Vpp       = r_ovpp;
  assign bus.Max_idx   = r_oidx;
  assign bus.Sum       = r_osum;
  assign bus.Vpp_found = r_found;
endmodule

// File: tb/tb_vpp_meter.sv
// Scoreboard bench for vpp_meter: an unsigned instance (u0) and a signed
// instance (u1). Expected results are queued as stimulus is issued; monitors
// pop and compare on every Vpp_found pulse.
module tb_vpp_meter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vpp_meter_if #(.DATA_W(12), .CNT_W(32)) if0 ();
  vpp_meter_if #(.DATA_W(12), .CNT_W(32)) if1 ();

  vpp_meter #(.DATA_W(12), .CNT_W(32), .SIGNED(0)) u0 (.clk_sample(clk), .rst(rst), .bus(if0));
  vpp_meter #(.DATA_W(12), .CNT_W(32), .SIGNED(1)) u1 (.clk_sample(clk), .rst(rst), .bus(if1));

  typedef struct packed {
    logic [11:0] mx;
    logic [11:0] mn;
    logic [12:0] vpp;
    logic [31:0] idx;
    logic [43:0] sum;
  } res_t;

  res_t q0[$];
  res_t q1[$];
  res_t e0, e1;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push0(input logic [11:0] mx, input logic [11:0] mn, input logic [12:0] vpp,
                       input logic [31:0] idx, input logic [43:0] sum);
    q0.push_back('{mx, mn, vpp, idx, sum});
  endtask

  task automatic step0(input logic v, input logic [11:0] d, input logic c);
    if0.Datain = d; if0.Datain_valid = v; if0.Clear = c;
    @(posedge clk); #1;
    if0.Clear = 1'b0; if0.Datain_valid = 1'b0;
  endtask

  task automatic step1(input logic v, input logic [11:0] d);
    if1.Datain = d; if1.Datain_valid = v;
    @(posedge clk); #1;
    if1.Datain_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (if0.Vpp_found === 1'b1) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL u0_unexpected_pulse: got pulse max=%0h min=%0h expected none", if0.Max, if0.Min);
      end else begin
        e0 = q0.pop_front();
        chk("u0_max", 64'(if0.Max), 64'(e0.mx));
        chk("u0_min", 64'(if0.Min), 64'(e0.mn));
        chk("u0_vpp", 64'(if0.Vpp), 64'(e0.vpp));
        chk("u0_idx", 64'(if0.Max_idx), 64'(e0.idx));
        chk("u0_sum", 64'(if0.Sum), 64'(e0.sum));
      end
    end
  end

  always @(negedge clk) begin
    if (if1.Vpp_found === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL u1_unexpected_pulse: got pulse max=%0h min=%0h expected none", if1.Max, if1.Min);
      end else begin
        e1 = q1.pop_front();
        chk("u1_max", 64'(if1.Max), 64'(e1.mx));
        chk("u1_min", 64'(if1.Min), 64'(e1.mn));
        chk("u1_vpp", 64'(if1.Vpp), 64'(e1.vpp));
        chk("u1_idx", 64'(if1.Max_idx), 64'(e1.idx));
        chk("u1_sum", 64'(if1.Sum), 64'(e1.sum));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk_out0(input string tag, input logic [11:0] mx, input logic [11:0] mn,
                          input logic [12:0] vpp, input logic [43:0] sum, input logic fnd);
    chk({tag, "_max"},   64'(if0.Max),       64'(mx));
    chk({tag, "_min"},   64'(if0.Min),       64'(mn));
    chk({tag, "_vpp"},   64'(if0.Vpp),       64'(vpp));
    chk({tag, "_sum"},   64'(if0.Sum),       64'(sum));
    chk({tag, "_found"}, 64'(if0.Vpp_found), 64'(fnd));
  endtask

  initial begin
    rst = 1'b1;
    if0.Datain = '0; if0.Datain_valid = 1'b0; if0.Times = 32'd4; if0.Hold = 1'b0; if0.Clear = 1'b0;
    if1.Datain = '0; if1.Datain_valid = 1'b0; if1.Times = 32'd3; if1.Hold = 1'b0; if1.Clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_out0("rst", 12'd0, 12'd0, 13'd0, 44'd0, 1'b0);
    chk("rst_idx", 64'(if0.Max_idx), 64'd0);
    chk("rst_u1_vpp", 64'(if1.Vpp), 64'd0);
    chk("rst_u1_found", 64'(if1.Vpp_found), 64'd0);
    rst = 1'b0;

    // Basic window, repeated back to back.
    for (int r = 0; r < 2; r++) begin
      push0(12'd9, 12'd2, 13'd7, 32'd1, 44'd25);
      step0(1, 12'd5, 0); step0(1, 12'd9, 0); step0(1, 12'd2, 0); step0(1, 12'd9, 0);
    end

    // Times change mid-window: abort, sample on the change cycle dropped.
    if0.Times = 32'd8;
    step0(0, 12'd0, 0);
    for (int i = 1; i <= 5; i++) step0(1, 12'(i), 0);
    if0.Times = 32'd2;
    step0(1, 12'd100, 0);
    chk_out0("tchg_hold", 12'd9, 12'd2, 13'd7, 44'd25, 1'b0);
    push0(12'd7, 12'd3, 13'd4, 32'd0, 44'd10);
    step0(1, 12'd7, 0); step0(1, 12'd3, 0);

    // Peak hold across windows, then Clear.
    if0.Hold = 1'b1;
    push0(12'd4, 12'd3, 13'd1, 32'd1, 44'd7);
    push0(12'd4, 12'd1, 13'd3, 32'd1, 44'd3);
    push0(12'd6, 12'd1, 13'd5, 32'd0, 44'd11);
    step0(1, 12'd3, 0); step0(1, 12'd4, 0);
    step0(1, 12'd1, 0); step0(1, 12'd2, 0);
    step0(1, 12'd6, 0); step0(1, 12'd5, 0);
    step0(0, 12'd0, 1);
    push0(12'd2, 12'd2, 13'd0, 32'd0, 44'd4);
    step0(1, 12'd2, 0); step0(1, 12'd2, 0);
    if0.Hold = 1'b0;
    step0(0, 12'd0, 1);

    // Times=0 acts as 1: a pulse per accepted sample.
    if0.Times = 32'd0;
    step0(0, 12'd0, 0);
    push0(12'd11, 12'd11, 13'd0, 32'd0, 44'd11);
    push0(12'd4, 12'd4, 13'd0, 32'd0, 44'd4);
    step0(1, 12'd11, 0); step0(1, 12'd4, 0);

    // Clear coincident with the last sample: dropped, no pulse.
    if0.Times = 32'd3;
    step0(0, 12'd0, 0);
    step0(1, 12'd1, 0); step0(1, 12'd2, 0); step0(1, 12'd3, 1);
    step0(0, 12'd0, 0);
    chk_out0("clr_last", 12'd4, 12'd4, 13'd0, 44'd4, 1'b0);
    push0(12'd8, 12'd6, 13'd2, 32'd2, 44'd21);
    step0(1, 12'd6, 0); step0(1, 12'd7, 0); step0(1, 12'd8, 0);

    // Reset mid-window, then a fresh window.
    step0(1, 12'd1, 0); step0(1, 12'd2, 0);
    rst = 1'b1;
    step0(0, 12'd0, 0);
    chk_out0("rst_mid", 12'd0, 12'd0, 13'd0, 44'd0, 1'b0);
    chk("rst_mid_idx", 64'(if0.Max_idx), 64'd0);
    rst = 1'b0;
    push0(12'd5, 12'd1, 13'd4, 32'd0, 44'd9);
    step0(1, 12'd5, 0); step0(1, 12'd1, 0); step0(1, 12'd3, 0);

    // Signed window with gaps on u1.
    q1.push_back('{12'h7FF, 12'h800, 13'h0FFF, 32'd1, {44{1'b1}}});
    step1(1, 12'h800); step1(0, 12'd0); step1(1, 12'h7FF);
    step1(0, 12'd0); step1(0, 12'd0); step1(1, 12'h000);

    repeat (4) step0(0, 12'd0, 0);
    chk("u0_queue_drained", 64'(q0.size()), 64'd0);
    chk("u1_queue_drained", 64'(q1.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vpp_meter.md
# vpp_meter

Parametrised windowed peak-to-peak meter for the sampled-signal path. It runs on the ADC sample clock and consumes one `Datain` word per valid cycle. Over a programmable window of `Times` samples it tracks max, min, peak-to-peak, sample sum and the window index of the maximum. It publishes results with a one-cycle `Vpp_found` pulse. An optional peak-hold mode keeps max/min running across windows until cleared.

## Interface
- `DATA_W`, 12: sample width.
- `CNT_W`, 32: width of the window counter and `Times`.
- `SIGNED`, 0: 1 means samples are two's complement, 0 means unsigned.

- `clk_sample`  in  1  sample clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `Datain`  in  DATA_W  sample.
- `Datain_valid`  in  1  sample qualifier; a sample is accepted only when high.
- `Times`  in  CNT_W  window length in accepted samples; 0 is treated as 1.
- `Hold`  in  1  peak-hold mode select.
- `Clear`  in  1  one-cycle command: abort the window and drop held peaks.
- `Max`  out  DATA_W  window (or held) maximum.
- `Min`  out  DATA_W  window (or held) minimum.
- `Vpp`  out  DATA_W+1  `Max - Min`, unsigned, zero-extended.
- `Max_idx`  out  CNT_W  window index (0-based) of the sample that set `Max`.
- `Sum`  out  DATA_W+CNT_W  sum of the window's samples; sign-extended when `SIGNED`=1.
- `Vpp_found`  out  1  one-cycle pulse: result registers were just updated.

## Operation
- Internal state:
  - `cnt`: accepted samples in the current window.
  - `acc_max`, `acc_min`, `acc_idx`, `acc_sum`.
  - `empty` flag.
  - `T_old`: registered copy of `Times`.
  - `hold_lat`: `Hold` as sampled at the last window start.
- Compare semantics follow `SIGNED`.
- **First sample after empty:** loads `acc_max` and `acc_min` with the sample and sets `acc_idx`=`cnt`. There are no 0 / all-ones seed values.
- **Later samples:**
  - Strictly greater than `acc_max`: update max and set `acc_idx`=`cnt`. Ties keep the first occurrence.
  - Strictly less than `acc_min`: update min.
- **Sum:** every accepted sample is added to `acc_sum` at full width, with no overflow possible for `Times` < 2^CNT_W.
- **Window end:** the accepted sample with `cnt` = max(`Times`,1)-1.
  - On that edge the output registers load the accumulator values including that sample.
  - `Vpp` is computed from the new values.
  - `cnt` returns to 0 and `acc_sum` returns to 0.
  - `hold_lat` takes the current `Hold`.
  - If the new `hold_lat`=0: `empty` is set, so max/min restart.
  - If the new `hold_lat`=1: `acc_max`, `acc_min` and `acc_idx` are retained.
- **Abort:** triggered by `Clear`=1 or by `Times`≠`T_old`.
  - `cnt`, `acc_sum` and `acc_idx` go to 0 and `empty` is set.
  - The incoming sample that cycle is dropped.
  - No pulse. Output registers keep their last values.
  - A new window starts on the next accepted sample.
- **Priority:** `rst` > abort > window end > normal accumulate.
- Output registers change only at window end or reset.
- `Datain_valid`=0 cycles are ignored entirely; the window counts only accepted samples.

## Timing
- **Reset** (`rst` high at an edge):
  - `Max`, `Min`, `Vpp`, `Max_idx`, `Sum` = 0 and `Vpp_found` = 0.
  - `cnt` = 0, `empty` = 1, `hold_lat` = 0, `T_old` = `Times`.
- **Latency:** results appear on the edge that accepts the last window sample. `Vpp_found` is registered and is high for exactly the cycle after that edge.
- **Throughput:** one sample per cycle, with back-to-back windows and no dead cycles. For `Times`=1, `Vpp_found` is high continuously while `Datain_valid` is high.
- **Change detection:** `T_old` updates every cycle, so a `Times` change causes exactly one abort cycle.
- **Window length:** the new `Times` value governs the window that starts after the abort.
- **Reset mid-window:** partial results are discarded and no pulse is produced.
- **`Hold` toggled mid-window:** takes effect only at the next window end.
- **Clear while `hold_lat`=1:** discards held peaks. The next window's max/min start fresh.

## Test plan
- **Basic window:** `SIGNED`=0, `Times`=4, samples 5, 9, 2, 9 with `Datain_valid` always high -> after the 4th sample: `Max`=9, `Min`=2, `Vpp`=7, `Max_idx`=1, `Sum`=25, one `Vpp_found` pulse. Repeating the stream gives a pulse every 4 cycles.
- **Signed and gaps:** `SIGNED`=1, `Times`=3, samples -2048, 2047, 0, with invalid cycles interleaved -> `Vpp`=4095, `Sum`=-1 sign-extended, pulse only after the 3rd accepted sample.
- **Times change mid-window:** `Times` 8→2 after 5 samples -> no pulse and outputs unchanged. The next 2 samples produce a pulse with results from those 2 samples only.
- **Peak hold:** `Hold`=1, `Times`=2, windows {3,4}, {1,2}, {6,5} -> `Max`/`Min` = 4/3, then 4/1, then 6/1. `Sum` = 7, 3, 11. Then `Clear`, then {2,2} -> `Max`=`Min`=2, `Vpp`=0.
- **Edge cases:**
  - `Times`=0 behaves as 1: every accepted sample pulses, with `Max`=`Min`=`Datain` and `Vpp`=0.
  - `Clear` coincident with the last sample -> sample dropped, no pulse.
- **Reset:** assert `rst` mid-window after prior results -> all outputs 0 the next cycle. A full window afterwards gives correct fresh results.
